// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding data-memory access unit between execute and
//   writeback. Accepts one load/store at a time, checks alignment/funct3,
//   issues a word-addressed bus request with byte enables, waits for
//   grant/read data and emits a one-cycle writeback pulse.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   in_valid/in_ready    op handshake from execute (ready only in IDLE)
//   in_is_store, in_funct3, in_addr, in_wdata, in_rd   op fields
//   dmem_req/we/addr/be/wdata   bus request, driven only in REQ
//   dmem_gnt, dmem_rvalid, dmem_rdata   bus response
//   wb_valid/rd/data/exc  completion pulse, driven only in DONE
//   exc: 00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [1:0]  wb_exc
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   typedef struct packed {
      logic        is_store;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } op_t;

   state_t          state, state_nxt;
   op_t             op;
   logic [CW-1:0]   cnt;
   logic [31:0]     rdata_q;
   logic [1:0]      exc_q;

   logic            illegal, misal;
   logic            cmpl, tmo, last;
   logic [3:0]      be;
   logic [31:0]     wrep;
   logic [15:0]     s;
   logic [31:0]     ext;

   // Capture-time checks on the incoming op. 11x already covers
   // funct3[2] with [1] set, so funct3[2] alone flags BU/HU stores.
   assign illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                    (in_funct3 == 3'b111) || (in_is_store && in_funct3[2]);
   assign misal   = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                    ((in_funct3 == 3'b010) && (in_addr[1:0] != 2'b00));

   // Request shaping from the captured op (stable for all of REQ).
   always_comb begin
      be   = 4'b1111;
      wrep = op.wdata;
      case (op.funct3[1:0])
         2'b00: begin
            be   = 4'b0001 << op.addr[1:0];
            wrep = {4{op.wdata[7:0]}};
         end
         2'b01: begin
            be   = 4'b0011 << op.addr[1:0];
            wrep = {2{op.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load data alignment and extension; only the low halfword of the
   // shifted word is ever needed.
   assign s = 16'(dmem_rdata >> {op.addr[1:0], 3'b000});
   always_comb begin
      case (op.funct3)
         3'b000:  ext = {{24{s[7]}}, s[7:0]};
         3'b100:  ext = {24'd0, s[7:0]};
         3'b001:  ext = {{16{s[15]}}, s};
         3'b101:  ext = {16'd0, s};
         default: ext = dmem_rdata;
      endcase
   end

   // cmpl: transaction finishes normally this cycle. tmo: the last
   // allowed REQ/WAIT cycle passes without completion.
   assign last = (cnt == CW'(TIMEOUT - 1));
   assign cmpl = ((state == REQ) && dmem_gnt && (op.is_store || dmem_rvalid)) ||
                 ((state == WAIT) && dmem_rvalid);
   assign tmo  = ((state == REQ) || (state == WAIT)) && !cmpl && last;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         op      <= '0;
         cnt     <= '0;
         rdata_q <= '0;
         exc_q   <= 2'b00;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               op.is_store <= in_is_store;
               op.funct3   <= in_funct3;
               op.addr     <= in_addr;
               op.wdata    <= in_wdata;
               op.rd       <= in_is_store ? 5'd0 : in_rd;
               cnt         <= '0;
               rdata_q     <= '0;
               exc_q       <= illegal ? 2'b10 : (misal ? 2'b01 : 2'b00);
            end
            REQ, WAIT: begin
               cnt <= cnt + 1'b1;
               if (cmpl && !op.is_store) rdata_q <= ext;
               if (tmo) exc_q <= 2'b11;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'd0;
      dmem_be    = 4'd0;
      dmem_wdata = 32'd0;
      wb_valid   = 1'b0;
      wb_rd      = 5'd0;
      wb_data    = 32'd0;
      wb_exc     = 2'b00;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (illegal || misal) ? DONE : REQ;
         end
         REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = op.is_store;
            dmem_addr  = {op.addr[31:2], 2'b00};
            dmem_be    = be;
            dmem_wdata = op.is_store ? wrep : 32'd0;
            if (cmpl || tmo)   state_nxt = DONE;
            else if (dmem_gnt) state_nxt = WAIT;
         end
         WAIT: if (cmpl || tmo) state_nxt = DONE;
         DONE: begin
            wb_valid  = 1'b1;
            wb_rd     = op.rd;
            wb_data   = rdata_q;
            wb_exc    = exc_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  wb_exc;

   int n_assert = 0;
   int n_fail   = 0;

   // results of the last transaction
   int          lat, req_cyc;
   logic        got, saw_req, post_ready, post_wb;
   logic        s_we;
   logic [31:0] s_addr, s_wdata, r_data;
   logic [3:0]  s_be;
   logic [1:0]  r_exc;
   logic [4:0]  r_rd;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one op from an idle negedge. gw: REQ cycles before gnt (large =
   // never). rw: cycles after gnt before rvalid (0 = same cycle as gnt).
   task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r,
                       input int gw, input int rw, input logic [31:0] rdat);
      in_valid = 1'b1; in_is_store = st; in_funct3 = f3;
      in_addr = a; in_wdata = d; in_rd = r; dmem_rdata = rdat;
      @(negedge clock);
      in_valid = 1'b0;
      lat = 1; req_cyc = 0; got = 1'b0; saw_req = 1'b0;
      s_we = dmem_we; s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata;
      while (!got && lat < 40) begin
         if (wb_valid) begin
            got = 1'b1; r_data = wb_data; r_exc = wb_exc; r_rd = wb_rd;
         end else begin
            if (dmem_req) begin saw_req = 1'b1; req_cyc++; end
            dmem_gnt    = (lat - 1 == gw);
            dmem_rvalid = !st && (lat - 1 == gw + rw);
            @(negedge clock);
            lat++;
         end
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      @(negedge clock);
      post_ready = in_ready; post_wb = wb_valid;
      chk("completion_seen", {31'd0, got}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
      in_addr = '0; in_wdata = '0; in_rd = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);

      // SB 0x1003, immediate grant
      xact(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd7, 0, 0, 32'h0);
      chk("sb_we",    {31'd0, s_we}, 32'd1);
      chk("sb_addr",  s_addr, 32'h1000);
      chk("sb_be",    {28'd0, s_be}, 32'h8);
      chk("sb_wdata", s_wdata, 32'hA5A5A5A5);
      chk("sb_lat",   lat, 2);
      chk("sb_exc",   {30'd0, r_exc}, 0);
      chk("sb_rd",    {27'd0, r_rd}, 0);
      chk("sb_data",  r_data, 0);
      chk("sb_post_ready", {31'd0, post_ready}, 1);
      chk("sb_post_wb",    {31'd0, post_wb}, 0);

      // LB 0x2001, 3 idle WAIT cycles
      xact(1'b0, 3'b000, 32'h2001, 32'h0, 5'd5, 0, 4, 32'h0000_8000);
      chk("lb_we",   {31'd0, s_we}, 0);
      chk("lb_addr", s_addr, 32'h2000);
      chk("lb_be",   {28'd0, s_be}, 32'h2);
      chk("lb_data", r_data, 32'hFFFFFF80);
      chk("lb_lat",  lat, 6);
      chk("lb_rd",   {27'd0, r_rd}, 5);
      chk("lb_exc",  {30'd0, r_exc}, 0);

      // LBU same
      xact(1'b0, 3'b100, 32'h2001, 32'h0, 5'd6, 0, 4, 32'h0000_8000);
      chk("lbu_data", r_data, 32'h00000080);

      // LH 0x2002, grant+rvalid together: minimum latency
      xact(1'b0, 3'b001, 32'h2002, 32'h0, 5'd9, 0, 0, 32'hBEEF_1234);
      chk("lh_be",   {28'd0, s_be}, 32'hC);
      chk("lh_data", r_data, 32'hFFFFBEEF);
      chk("lh_lat",  lat, 2);
      chk("lh_post_ready", {31'd0, post_ready}, 1);

      // LW 0x2002 misaligned
      xact(1'b0, 3'b010, 32'h2002, 32'h0, 5'd3, 0, 0, 32'h1234_5678);
      chk("lw_mis_exc", {30'd0, r_exc}, 32'h1);
      chk("lw_mis_req", {31'd0, saw_req}, 0);
      chk("lw_mis_data", r_data, 0);

      // SH 0x4002 with grant after 2 cycles
      xact(1'b1, 3'b001, 32'h4002, 32'h1234_ABCD, 5'd1, 2, 0, 32'h0);
      chk("sh_be",    {28'd0, s_be}, 32'hC);
      chk("sh_wdata", s_wdata, 32'hABCDABCD);
      chk("sh_lat",   lat, 4);

      // SW 0x3000, never granted
      xact(1'b1, 3'b010, 32'h3000, 32'hDEAD_BEEF, 5'd2, 1000, 0, 32'h0);
      chk("sw_to_be",  {28'd0, s_be}, 32'hF);
      chk("sw_to_req_cycles", req_cyc, 16);
      chk("sw_to_exc", {30'd0, r_exc}, 32'h3);
      chk("sw_to_lat", lat, 17);
      chk("sw_to_post_ready", {31'd0, post_ready}, 1);

      // illegal funct3 load and store with BU encoding
      xact(1'b0, 3'b011, 32'h5000, 32'h0, 5'd4, 0, 0, 32'h0);
      chk("f3_011_exc", {30'd0, r_exc}, 32'h2);
      chk("f3_011_req", {31'd0, saw_req}, 0);
      xact(1'b1, 3'b100, 32'h5000, 32'h11, 5'd4, 0, 0, 32'h0);
      chk("sbu_exc", {30'd0, r_exc}, 32'h2);

      // reset during WAIT
      in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h6000; in_rd = 5'd8;
      @(negedge clock);
      in_valid = 1'b0; dmem_gnt = 1'b1;
      @(negedge clock);
      dmem_gnt = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_wait_wb",    {31'd0, wb_valid}, 0);
      chk("rst_wait_ready", {31'd0, in_ready}, 1);
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clock);
      dmem_rvalid = 1'b0;
      chk("rst_wait_late_rvalid", {31'd0, wb_valid}, 0);

      // reset while request is outstanding
      in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b010; in_addr = 32'h7000;
      @(negedge clock);
      in_valid = 1'b0;
      chk("rst_req_req_up", {31'd0, dmem_req}, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_req_dropped", {31'd0, dmem_req}, 0);
      dmem_gnt = 1'b1;
      @(negedge clock);
      dmem_gnt = 1'b0;
      chk("rst_req_late_gnt_wb", {31'd0, wb_valid}, 0);
      chk("rst_req_ready", {31'd0, in_ready}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles from entering REQ to transaction completion before a bus error is reported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  execute stage presents a memory op this cycle.
REQ-005 in_ready  output  1  unit can accept an op; equals (state==IDLE).
REQ-006 in_is_store  input  1  1 = store, 0 = load.
REQ-007 in_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 in_addr  input  32  effective address (ALU result).
REQ-009 in_wdata  input  32  store data (rs2).
REQ-010 in_rd  input  5  load destination register.
REQ-011 dmem_req  output  1  memory request, held until granted.
REQ-012 dmem_we  output  1  1 = write.
REQ-013 dmem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-014 dmem_be  output  4  byte enables.
REQ-015 dmem_wdata  output  32  lane-replicated store data.
REQ-016 dmem_gnt  input  1  memory accepted the request this cycle.
REQ-017 dmem_rvalid  input  1  read data valid.
REQ-018 dmem_rdata  input  32  read word.
REQ-019 wb_valid  output  1  one-cycle completion pulse.
REQ-020 wb_rd  output  5  captured rd (0 for stores).
REQ-021 wb_data  output  32  extended load data (0 for stores and errors).
REQ-022 wb_exc  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.

Function
REQ-023 States: IDLE, REQ, WAIT, DONE; op fields captured on in_valid && in_ready.
REQ-024 Capture checks: illegal funct3 (011,110,111, or 100/101 with store) -> exc 10; else H with addr[0]!=0, or W with addr[1:0]!=0 -> exc 01; either -> next state DONE, no dmem_req ever asserted.
REQ-025 Legal op -> REQ; dmem_req=1 and dmem_we/addr/be/wdata stable in REQ until dmem_gnt sampled high.
REQ-026 Store: be B = 0001<<addr[1:0], H = 0011<<addr[1:0], W = 1111; wdata B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
REQ-027 Load: dmem_we=0, be per REQ-026 rule.
REQ-028 REQ with gnt: store -> DONE; load -> WAIT, or DONE directly if dmem_rvalid also high same cycle.
REQ-029 WAIT: on dmem_rvalid, latch extended data -> DONE; rvalid outside REQ/WAIT is ignored.
REQ-030 Extraction: s = rdata >> (8*addr[1:0]); B = sext(s[7:0]), BU = zext(s[7:0]), H = sext(s[15:0]), HU = zext(s[15:0]), W = rdata.
REQ-031 Timeout counter clears on entry to REQ, increments each REQ/WAIT cycle; when it reaches TIMEOUT without completion -> DONE with exc 11, dmem_req dropped.
REQ-032 DONE lasts exactly one cycle: wb_valid=1 with wb_rd/wb_data/wb_exc; then IDLE.
REQ-033 Minimum latency: accept cycle N, gnt+rvalid in cycle N+1 -> wb_valid in N+2; unit accepts next op in N+3.
REQ-034 in_valid while in_ready=0 is ignored; op is not lost upstream (upstream holds).
REQ-035 All outputs except wb_* in DONE and dmem_* in REQ are 0.

Reset
REQ-036 reset forces IDLE, counter 0, all outputs 0, in_ready=1 on following cycle, overriding any in-flight op (no wb_valid generated for it).
REQ-037 Reset asserted while dmem_req=1 drops dmem_req next cycle; later gnt/rvalid ignored.

Verification
REQ-038 SB addr 0x1003 data 0xA5, gnt immediate -> be=1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, wb_valid 2 cycles after accept, exc 00.
REQ-039 LB addr 0x2001, rdata 0x0000_8000 after 3 WAIT cycles -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 LH addr 0x2002, rdata 0xBEEF_1234 -> wb_data=0xFFFFBEEF; LW addr 0x2002 -> no dmem_req, exc 01.
REQ-041 SW addr 0x3000, gnt never -> dmem_req held TIMEOUT cycles, then wb_valid with exc 11.
REQ-042 funct3=011 load -> exc 10, no request; reset during WAIT -> no wb_valid, in_ready=1 next cycle.
